// File: rtl/mem_write_trace.sv
// Data-memory write tracer: captures {pc, addr, data} of every store into a
// FIFO while armed, freezing capture once the PC reaches STOP_PC.
module mem_write_trace #(
    parameter int          DEPTH   = 8,
    parameter logic [31:0] STOP_PC = 32'h00000100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc_current,
    input  logic [31:0]              alu_out,
    input  logic [31:0]              wd_dm,
    input  logic                     we_dm,
    input  logic                     arm,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              overflow_cnt,
    output logic                     frozen
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2
    } state_t;

    state_t        state_q;
    logic          frozen_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [15:0]   ovf_q;
    logic [95:0]   head_q;
    logic [95:0]   head_d;
    logic [95:0]   wr_entry;
    logic [95:0]   mem [DEPTH];

    logic full;
    logic pop;
    logic capture;
    logic push;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        pop      = (count_q != '0) && out_ready;
        capture  = (state_q == S_RUN) && (we_dm === 1'b1);
        push     = capture && (!full || pop);
        wr_entry = {pc_current, alu_out, wd_dm};
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        // The head register is reloaded for the post-edge head; when that head
        // is the entry being written this edge, take it from the write path.
        head_d   = head_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = wr_entry;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            frozen_q <= 1'b0;
            ovf_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (capture && full && !pop && (ovf_q != 16'hFFFF)) begin
                        ovf_q <= ovf_q + 16'd1;
                    end
                    if (pc_current == STOP_PC) begin
                        state_q  <= S_FROZEN;
                        frozen_q <= 1'b1;
                    end
                end
                S_FROZEN: begin
                    // Resuming starts a fresh drop count; buffered entries remain.
                    if (arm) begin
                        state_q  <= S_RUN;
                        frozen_q <= 1'b0;
                        ovf_q    <= '0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    frozen_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid    = (count_q != '0);
    assign out_pc       = head_q[95:64];
    assign out_addr     = head_q[63:32];
    assign out_data     = head_q[31:0];
    assign count        = count_q;
    assign overflow_cnt = ovf_q;
    assign frozen       = frozen_q;

endmodule

// File: tb/tb_mem_write_trace.sv
// Bench for mem_write_trace: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_write_trace;

    localparam int          DEPTH   = 8;
    localparam logic [31:0] STOP_PC = 32'h00000100;
    localparam int M_IDLE = 0, M_RUN = 1, M_FROZEN = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_current = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] wd_dm = '0;
    logic        we_dm = 1'b0;
    logic        arm = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic [15:0] overflow_cnt;
    logic        frozen;

    mem_write_trace #(.DEPTH(DEPTH), .STOP_PC(STOP_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_current   (pc_current),
        .alu_out      (alu_out),
        .wd_dm        (wd_dm),
        .we_dm        (we_dm),
        .arm          (arm),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .count        (count),
        .overflow_cnt (overflow_cnt),
        .frozen       (frozen)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [95:0] mq[$];
    int          mstate;
    logic [15:0] movf;
    bit          ever_cap;
    bit          chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        mstate   = M_IDLE;
        movf     = '0;
        ever_cap = 0;
    endtask

    // Applies one rising edge worth of behaviour to the model.
    task automatic model_step();
        bit was_full, do_pop, do_cap;
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() != 0) && out_ready;
        do_cap   = (mstate == M_RUN) && (we_dm === 1'b1);
        if (do_pop) void'(mq.pop_front());
        if (do_cap) begin
            if (!was_full || do_pop) begin
                mq.push_back({pc_current, alu_out, wd_dm});
                ever_cap = 1;
            end else if (movf != 16'hFFFF) begin
                movf++;
            end
        end
        case (mstate)
            M_IDLE:   if (arm) mstate = M_RUN;
            M_RUN:    if (pc_current == STOP_PC) mstate = M_FROZEN;
            M_FROZEN: if (arm) begin mstate = M_RUN; movf = '0; end
            default:  mstate = M_IDLE;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("count", 32'(count), mq.size());
            chk("overflow", 32'(overflow_cnt), 32'(movf));
            chk("frozen", 32'(frozen), 32'(mstate == M_FROZEN));
            if (mq.size() != 0) begin
                chk("head_pc", out_pc, mq[0][95:64]);
                chk("head_addr", out_addr, mq[0][63:32]);
                chk("head_data", out_data, mq[0][31:0]);
            end else if (!ever_cap) begin
                chk("idle_pc", out_pc, 32'h0);
                chk("idle_data", out_data, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] pc, input logic [31:0] addr,
                      input logic [31:0] data, input logic rdy);
        we_dm = 1'b1; pc_current = pc; alu_out = addr; wd_dm = data;
        out_ready = rdy; arm = 1'b0;
        tick();
        we_dm = 1'b0; out_ready = 1'b0;
        pc_current = 32'h0000_0F00;
    endtask

    task automatic idle(input logic rdy);
        we_dm = 1'b0; out_ready = rdy; arm = 1'b0;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1; we_dm = 1'b0; out_ready = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        model_reset();
        pc_current = 32'h0000_0F00;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_ovf", 32'(overflow_cnt), 32'h0);
        chk("rst_frozen", 32'(frozen), 32'h0);
        rst = 1'b1;
        chk_en = 1;

        // Basic capture and pop; a write before arming is ignored.
        wr(32'h8, 32'h54, 32'h7, 1'b0);
        chk("noarm_count", 32'(count), 32'h0);
        do_arm();
        wr(32'h8, 32'h54, 32'h7, 1'b0);
        chk("basic_valid", 32'(out_valid), 32'h1);
        chk("basic_pc", out_pc, 32'h8);
        chk("basic_addr", out_addr, 32'h54);
        chk("basic_data", out_data, 32'h7);
        chk("basic_count", 32'(count), 32'h1);
        idle(1'b1);
        chk("basic_pop_count", 32'(count), 32'h0);
        chk("basic_pop_valid", 32'(out_valid), 32'h0);

        // Overflow: ten writes into an eight-deep FIFO.
        for (int i = 0; i < 10; i++) wr(32'h10 + i, 32'h1000 + i, i + 1, 1'b0);
        chk("ovf_count", 32'(count), 32'h8);
        chk("ovf_cnt", 32'(overflow_cnt), 32'h2);
        chk("ovf_head", out_data, 32'h1);
        // Full with simultaneous pop and write.
        wr(32'h40, 32'h2000, 32'hB, 1'b1);
        chk("fullsim_count", 32'(count), 32'h8);
        chk("fullsim_ovf", 32'(overflow_cnt), 32'h2);
        chk("fullsim_head", out_data, 32'h2);
        for (int k = 0; k < 8; k++) begin
            chk("drain_order", out_data, (k < 7) ? 32'(k + 2) : 32'hB);
            idle(1'b1);
        end
        chk("drain_count", 32'(count), 32'h0);

        // Freeze on STOP_PC; the matching write is still captured.
        wr(STOP_PC, 32'h3000, 32'hF0, 1'b0);
        chk("frz_frozen", 32'(frozen), 32'h1);
        chk("frz_count", 32'(count), 32'h1);
        chk("frz_pc", out_pc, 32'h100);
        wr(32'h104, 32'h3004, 32'hF1, 1'b0);
        chk("frz_ignored", 32'(count), 32'h1);
        chk("frz_ovf_kept", 32'(overflow_cnt), 32'h2);
        do_arm();
        chk("resume_frozen", 32'(frozen), 32'h0);
        chk("resume_ovf", 32'(overflow_cnt), 32'h0);
        wr(32'h108, 32'h3008, 32'hF2, 1'b0);
        chk("resume_count", 32'(count), 32'h2);
        idle(1'b1);
        chk("resume_head", out_data, 32'hF2);
        idle(1'b1);

        // Asynchronous reset mid-run discards buffered entries.
        for (int i = 0; i < 3; i++) wr(32'h500 + i, 32'h5000 + i, 32'hA0 + i, 1'b0);
        chk("pre_rst_count", 32'(count), 32'h3);
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'h0);
        chk("async_count", 32'(count), 32'h0);
        chk("async_pc", out_pc, 32'h0);
        chk("async_data", out_data, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) wr(32'h600 + i, 32'h6000 + i, 32'hB0 + i, 1'b0);
        chk("noautoarm_count", 32'(count), 32'h0);

        // Pointer wrap through repeated write/pop pairs.
        do_arm();
        for (int i = 0; i < 20; i++) begin
            wr(32'h200 + 4 * i, 32'h4000 + i, 32'h500 + i, 1'b1);
            chk("wrap_count_le1", 32'(count <= 1), 32'h1);
        end
        chk("wrap_last", out_data, 32'h513);
        idle(1'b1);
        chk("wrap_empty", 32'(count), 32'h0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
